// File: rtl/modbus_pkg.sv
// Shared Modbus definitions: arbiter state encoding, write status codes,
// the handler's exception code and the holding-register address decode.
package modbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_MB  = 2'd1,
    ST_GNT_LOC = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic       MB_OK               = 1'b0;
  localparam logic       MB_ILLEGAL_ADDR     = 1'b1;
  localparam logic [7:0] MB_EXC_ILLEGAL_ADDR = 8'h02;

  // Requester bit positions in the arbiter request/grant vectors
  localparam int REQ_MB  = 0;
  localparam int REQ_LOC = 1;

  // Legal iff addr >= base and (addr - base) < num, with 16-bit wrap on the subtract
  function automatic logic addr_legal(input logic [15:0] addr, input logic [15:0] base,
                                      input int num);
    logic [15:0] idx;
    idx = addr - base;
    return (addr >= base) && (int'(idx) < num);
  endfunction

endpackage

// File: rtl/holding_reg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester not granted last
// wins; last_grant only moves when the caller commits a grant via advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0: requester 0 (MB) granted last, 1: requester 1 (LOC) granted last
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
    else              gnt = req;
  end

  // Reset to "LOC last" so MB takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        last_grant <= 1'b1;
    else if (advance && (gnt != 2'b00)) last_grant <= gnt[1];
  end

endmodule

// File: rtl/holding_reg_arbiter.sv
// Modbus holding-register bank shared between the function handler's write
// pulse (MB) and a level-handshaked local master (LOC), one grant per 3 cycles.
module holding_reg_arbiter
  import modbus_pkg::*;
#(
  parameter int          REG_NUM   = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] RST_VAL   = 16'h0000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   mb_wen,
  input  logic [15:0]            mb_waddr,
  input  logic [15:0]            mb_wdat,
  output logic                   mb_w_done,
  output logic                   mb_w_status,
  input  logic                   loc_req,
  input  logic                   loc_we,
  input  logic [15:0]            loc_addr,
  input  logic [15:0]            loc_wdat,
  output logic                   loc_ack,
  output logic [15:0]            loc_rdat,
  output logic                   loc_err,
  output logic [16*REG_NUM-1:0]  reg_flat,
  output logic [REG_NUM-1:0]     reg_update
);

  state_t                    state, state_nxt;
  logic [REG_NUM-1:0][15:0]  bank;

  logic        mb_pend;
  logic [15:0] mb_addr_q, mb_dat_q;
  logic        loc_we_q;
  logic [15:0] loc_addr_q, loc_dat_q;

  logic [1:0]  req, gnt;
  logic        advance;

  logic               sel_mb, in_gnt, sel_we, sel_legal;
  logic [15:0]        sel_addr, sel_dat, sel_idx, rd_val;
  logic [REG_NUM-1:0] sel_hot;

  assign reg_flat = bank;

  // LOC is only considered while IDLE; a request dropped before then simply vanishes
  assign req     = {loc_req, mb_pend};
  assign advance = (state == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt[REQ_MB])       state_nxt = ST_GNT_MB;
        else if (gnt[REQ_LOC]) state_nxt = ST_GNT_LOC;
      end
      ST_GNT_MB, ST_GNT_LOC: state_nxt = ST_RESP;
      ST_RESP:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Decode of whichever request currently holds the grant
  always_comb begin
    sel_mb    = (state == ST_GNT_MB);
    in_gnt    = sel_mb || (state == ST_GNT_LOC);
    sel_addr  = sel_mb ? mb_addr_q : loc_addr_q;
    sel_dat   = sel_mb ? mb_dat_q  : loc_dat_q;
    sel_we    = sel_mb || loc_we_q;
    sel_idx   = sel_addr - BASE_ADDR;
    sel_legal = addr_legal(sel_addr, BASE_ADDR, REG_NUM);
    sel_hot   = '0;
    rd_val    = 16'h0000;
    for (int i = 0; i < REG_NUM; i++) begin
      if (sel_legal && (sel_idx == 16'(i))) begin
        sel_hot[i] = 1'b1;
        rd_val     = bank[i];
      end
    end
  end

  // MB capture: a second pulse while one is pending is dropped on purpose
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mb_pend   <= 1'b0;
      mb_addr_q <= 16'h0000;
      mb_dat_q  <= 16'h0000;
    end else if (state == ST_GNT_MB) begin
      mb_pend <= 1'b0;
    end else if (mb_wen && !mb_pend) begin
      mb_pend   <= 1'b1;
      mb_addr_q <= mb_waddr;
      mb_dat_q  <= mb_wdat;
    end
  end

  // LOC fields are frozen at grant so a master dropping req mid-grant still completes cleanly
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      loc_we_q   <= 1'b0;
      loc_addr_q <= 16'h0000;
      loc_dat_q  <= 16'h0000;
    end else if ((state == ST_IDLE) && gnt[REQ_LOC]) begin
      loc_we_q   <= loc_we;
      loc_addr_q <= loc_addr;
      loc_dat_q  <= loc_wdat;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bank       <= {REG_NUM{RST_VAL}};
      reg_update <= '0;
    end else begin
      reg_update <= '0;
      if (in_gnt && sel_we) begin
        for (int i = 0; i < REG_NUM; i++)
          if (sel_hot[i]) bank[i] <= sel_dat;
        reg_update <= sel_hot;
      end
    end
  end

  // Completion flags register out of the grant cycle, so they pulse exactly in RESP
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mb_w_done   <= 1'b0;
      mb_w_status <= MB_OK;
      loc_ack     <= 1'b0;
      loc_err     <= 1'b0;
      loc_rdat    <= 16'h0000;
    end else begin
      mb_w_done   <= sel_mb;
      mb_w_status <= (sel_mb && !sel_legal) ? MB_ILLEGAL_ADDR : MB_OK;
      loc_ack     <= (state == ST_GNT_LOC);
      loc_err     <= (state == ST_GNT_LOC) && !sel_legal;
      if (state == ST_GNT_LOC) begin
        if (!sel_legal)     loc_rdat <= 16'h0000;
        else if (!loc_we_q) loc_rdat <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_holding_reg_arbiter.sv
// Scoreboard bench for holding_reg_arbiter: scenarios push expected responses,
// a forked monitor pops and compares them whenever done/ack pulses.
module tb_holding_reg_arbiter;
  import modbus_pkg::*;

  localparam int REG_NUM = 8;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in = 1'b0;
  logic                  mb_wen = 1'b0;
  logic [15:0]           mb_waddr = 16'h0;
  logic [15:0]           mb_wdat = 16'h0;
  logic                  mb_w_done, mb_w_status;
  logic                  loc_req = 1'b0;
  logic                  loc_we = 1'b0;
  logic [15:0]           loc_addr = 16'h0;
  logic [15:0]           loc_wdat = 16'h0;
  logic                  loc_ack, loc_err;
  logic [15:0]           loc_rdat;
  logic [16*REG_NUM-1:0] reg_flat;
  logic [REG_NUM-1:0]    reg_update;

  holding_reg_arbiter #(.REG_NUM(REG_NUM), .BASE_ADDR(16'h0000), .RST_VAL(16'h0000)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .mb_wen(mb_wen), .mb_waddr(mb_waddr), .mb_wdat(mb_wdat),
    .mb_w_done(mb_w_done), .mb_w_status(mb_w_status),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdat(loc_wdat),
    .loc_ack(loc_ack), .loc_rdat(loc_rdat), .loc_err(loc_err),
    .reg_flat(reg_flat), .reg_update(reg_update)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic               is_loc;
    logic               status;
    logic               chk_rdat;
    logic [15:0]        rdat;
    logic [REG_NUM-1:0] upd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model[REG_NUM];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_mb_done = 0;
  int          n_loc_ack = 0;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && (mb_w_done || loc_ack)) begin
        if (mb_w_done) n_mb_done++;
        if (loc_ack)   n_loc_ack++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: done=%0b ack=%0b, nothing expected", mb_w_done, loc_ack);
        end else begin
          e = exp_q.pop_front();
          if (loc_ack !== e.is_loc || mb_w_done !== !e.is_loc) begin
            n_fail++;
            $display("FAIL resp_kind: done=%0b ack=%0b, expected loc=%0b", mb_w_done, loc_ack, e.is_loc);
          end
          n_checks++;
          if ((e.is_loc ? loc_err : mb_w_status) !== e.status) begin
            n_fail++;
            $display("FAIL resp_status: got %0b expected %0b (loc=%0b)",
                     e.is_loc ? loc_err : mb_w_status, e.status, e.is_loc);
          end
          n_checks++;
          if (reg_update !== e.upd) begin
            n_fail++;
            $display("FAIL resp_update: got %h expected %h", reg_update, e.upd);
          end
          if (e.chk_rdat) begin
            n_checks++;
            if (loc_rdat !== e.rdat) begin
              n_fail++;
              $display("FAIL resp_rdat: got %h expected %h", loc_rdat, e.rdat);
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    mb_wen = 1'b0; loc_req = 1'b0;
    tick(2);
    rst_n_in = 1'b1;
    exp_q.delete();
    foreach (model[i]) model[i] = 16'h0000;
    tick();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    foreach (model[i]) model[i] = 16'h0000;
    tick(2);
    n_checks++;
    if (reg_flat !== '0) begin
      n_fail++; $display("FAIL reset_bank: got %h expected all 0", reg_flat);
    end
    n_checks++;
    if ({mb_w_done, mb_w_status, loc_ack, loc_err} !== 4'b0 || reg_update !== '0 || loc_rdat !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%0b st=%0b ack=%0b err=%0b upd=%h rdat=%h expected all 0",
               mb_w_done, mb_w_status, loc_ack, loc_err, reg_update, loc_rdat);
    end
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_mb_write();
    mb_wen = 1'b1; mb_waddr = 16'h0002; mb_wdat = 16'hBEEF;
    exp_q.push_back('{1'b0, MB_OK, 1'b0, 16'h0, 8'h04});
    model[2] = 16'hBEEF;
    tick();
    mb_wen = 1'b0;
    tick();
    n_checks++;
    if (mb_w_done !== 1'b0) begin
      n_fail++; $display("FAIL mb_write_early: done=%0b in cycle 2, expected 0", mb_w_done);
    end
    tick();
    n_checks++;
    if (mb_w_done !== 1'b1) begin
      n_fail++; $display("FAIL mb_write_latency: done=%0b in cycle 3, expected 1", mb_w_done);
    end
    n_checks++;
    if (reg_flat[47:32] !== 16'hBEEF) begin
      n_fail++; $display("FAIL mb_write_value: reg2=%h expected BEEF", reg_flat[47:32]);
    end
    tick(2);
  endtask

  // Upper legal boundary, first illegal address and a far wrap-around address
  task automatic test_illegal();
    logic [15:0] addrs[3];
    logic        legal[3];
    logic [REG_NUM-1:0] oh;
    addrs[0] = 16'h0007; legal[0] = 1'b1;
    addrs[1] = 16'h0008; legal[1] = 1'b0;
    addrs[2] = 16'hFFFF; legal[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      oh = '0;
      if (legal[t]) oh[addrs[t][2:0]] = 1'b1;
      mb_wen = 1'b1; mb_waddr = addrs[t]; mb_wdat = 16'h7000 + 16'(t);
      exp_q.push_back('{1'b0, legal[t] ? MB_OK : MB_ILLEGAL_ADDR, 1'b0, 16'h0, oh});
      if (legal[t]) model[addrs[t][2:0]] = 16'h7000 + 16'(t);
      tick();
      mb_wen = 1'b0;
      tick(2);
      n_checks++;
      if (mb_w_done !== 1'b1) begin
        n_fail++; $display("FAIL illegal_done: addr %h done=%0b expected 1", addrs[t], mb_w_done);
      end
      for (int i = 0; i < REG_NUM; i++) begin
        n_checks++;
        if (reg_flat[16*i +: 16] !== model[i]) begin
          n_fail++; $display("FAIL illegal_bank: reg%0d=%h expected %h", i, reg_flat[16*i +: 16], model[i]);
        end
      end
      tick(2);
    end
  endtask

  // mb_wen is raised a cycle ahead of loc_req so both requests meet in the same IDLE cycle
  task automatic do_tie(input logic [15:0] a, input logic [15:0] md, input logic [15:0] ld);
    logic [REG_NUM-1:0] oh;
    oh = '0; oh[a[2:0]] = 1'b1;
    mb_wen = 1'b1; mb_waddr = a; mb_wdat = md;
    exp_q.push_back('{1'b0, MB_OK, 1'b0, 16'h0, oh});
    tick();
    mb_wen = 1'b0;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = a; loc_wdat = ld;
    exp_q.push_back('{1'b1, MB_OK, 1'b0, 16'h0, oh});
    tick(2);
    n_checks++;
    if (mb_w_done !== 1'b1 || loc_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_mb_first: done=%0b ack=%0b expected done=1 ack=0", mb_w_done, loc_ack);
    end
    tick(3);
    n_checks++;
    if (loc_ack !== 1'b1) begin
      n_fail++; $display("FAIL tie_loc_second: ack=%0b 3 cycles after MB, expected 1", loc_ack);
    end
    loc_req = 1'b0;
    model[a[2:0]] = ld;
    tick();
    n_checks++;
    if (reg_flat[16*a[2:0] +: 16] !== ld) begin
      n_fail++; $display("FAIL tie_last_wins: reg%0d=%h expected %h", a, reg_flat[16*a[2:0] +: 16], ld);
    end
  endtask

  task automatic test_tie();
    do_reset();
    do_tie(16'h0001, 16'h1111, 16'h2222);
    do_tie(16'h0001, 16'h3333, 16'h4444);
    tick(2);
  endtask

  task automatic test_loc_read();
    mb_wen = 1'b1; mb_waddr = 16'h0003; mb_wdat = 16'h1234;
    exp_q.push_back('{1'b0, MB_OK, 1'b0, 16'h0, 8'h08});
    model[3] = 16'h1234;
    tick();
    mb_wen = 1'b0;
    tick(4);
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 16'h0003; loc_wdat = 16'hDEAD;
    exp_q.push_back('{1'b1, 1'b0, 1'b1, 16'h1234, 8'h00});
    tick();
    n_checks++;
    if (loc_ack !== 1'b0) begin
      n_fail++; $display("FAIL loc_read_early: ack=%0b at k+1, expected 0", loc_ack);
    end
    tick();
    n_checks++;
    if (loc_ack !== 1'b1 || loc_rdat !== 16'h1234) begin
      n_fail++; $display("FAIL loc_read_ack: ack=%0b rdat=%h at k+2, expected 1/1234", loc_ack, loc_rdat);
    end
    loc_req = 1'b0;
    tick(3);
    n_checks++;
    if (loc_rdat !== 16'h1234) begin
      n_fail++; $display("FAIL loc_rdat_hold: rdat=%h expected 1234", loc_rdat);
    end
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 16'h0009;
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 16'h0000, 8'h00});
    tick(2);
    loc_req = 1'b0;
    tick(2);
  endtask

  task automatic test_abandon();
    int base_done, base_ack;
    base_done = n_mb_done; base_ack = n_loc_ack;
    mb_wen = 1'b1; mb_waddr = 16'h0005; mb_wdat = 16'hAAAA;
    exp_q.push_back('{1'b0, MB_OK, 1'b0, 16'h0, 8'h20});
    model[5] = 16'hAAAA;
    tick();
    mb_waddr = 16'h0006; mb_wdat = 16'h5555;
    tick();
    mb_wen = 1'b0;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 16'h0006; loc_wdat = 16'h6666;
    tick();
    loc_req = 1'b0;
    tick(6);
    n_checks++;
    if (n_mb_done - base_done != 1) begin
      n_fail++; $display("FAIL abandon_done_count: got %0d expected 1", n_mb_done - base_done);
    end
    n_checks++;
    if (n_loc_ack != base_ack) begin
      n_fail++; $display("FAIL abandon_no_ack: got %0d acks expected 0", n_loc_ack - base_ack);
    end
    for (int i = 0; i < REG_NUM; i++) begin
      n_checks++;
      if (reg_flat[16*i +: 16] !== model[i]) begin
        n_fail++; $display("FAIL abandon_bank: reg%0d=%h expected %h", i, reg_flat[16*i +: 16], model[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base_ack;
    base_ack = n_loc_ack;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 16'h0001; loc_wdat = 16'h7777;
    tick();
    rst_n_in = 1'b0;
    loc_req = 1'b0;
    tick(2);
    rst_n_in = 1'b1;
    foreach (model[i]) model[i] = 16'h0000;
    tick(4);
    n_checks++;
    if (n_loc_ack != base_ack) begin
      n_fail++; $display("FAIL reset_mid_ack: got %0d acks expected 0", n_loc_ack - base_ack);
    end
    n_checks++;
    if (reg_flat !== '0) begin
      n_fail++; $display("FAIL reset_mid_bank: got %h expected all 0", reg_flat);
    end
    do_tie(16'h0000, 16'h0A0A, 16'h0B0B);
    tick(2);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_mb_write();
    test_illegal();
    test_tie();
    test_loc_read();
    test_abandon();
    test_reset_mid();
    tick(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
